// File: rtl/dns_pkt_arbiter_pkg.sv
// Shared DNS/UDP constants and the header bundle
// carried through the arbiter output stage.
package dns_pkt_arbiter_pkg;

    localparam logic [15:0] DNS_UDP_PORT = 16'd53;
    localparam int UDP_HDR_LEN   = 8;
    localparam int DNS_HDR_LEN   = 12;
    localparam int DNS_PKT_WIDTH = 4096;
    localparam int DNS_MIN_LEN   = UDP_HDR_LEN + DNS_HDR_LEN;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] length;
    } udp_hdr_t;

endpackage

// File: rtl/dns_pkt_arbiter_rr.sv
// Combinational round-robin pick: first requester
// after last_grant, wrapping modulo N_PORTS.
module dns_rr_arbiter #(
    parameter int N_PORTS = 4,
    localparam int IW = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [N_PORTS-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_any
);

    int pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            pos = (int'(last_grant) + k) % N_PORTS;
            if (!grant_any && req[IW'(pos)]) begin
                grant[IW'(pos)] = 1'b1;
                grant_idx       = IW'(pos);
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dns_pkt_arbiter.sv
// Round-robin DNS packet arbiter: runt filter,
// registered output stage, saturating statistics.
module dns_pkt_arbiter
    import dns_pkt_arbiter_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int PKT_WIDTH = DNS_PKT_WIDTH,
    parameter int MIN_LEN   = DNS_MIN_LEN,
    parameter int CNT_WIDTH = 16,
    localparam int IW = $clog2(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [N_PORTS-1:0]             s_dns_valid,
    output logic [N_PORTS-1:0]             s_dns_ready,
    input  logic [N_PORTS*32-1:0]          s_udp_src_ip,
    input  logic [N_PORTS*32-1:0]          s_udp_dst_ip,
    input  logic [N_PORTS*16-1:0]          s_udp_length,
    input  logic [N_PORTS*PKT_WIDTH-1:0]   s_dns_pkt,
    output logic                           m_dns_valid,
    input  logic                           m_dns_ready,
    output logic [31:0]                    m_udp_src_ip,
    output logic [31:0]                    m_udp_dst_ip,
    output logic [15:0]                    m_udp_length,
    output logic [PKT_WIDTH-1:0]           m_dns_pkt,
    output logic [IW-1:0]                  m_dns_port,
    output logic [CNT_WIDTH-1:0]           stat_fwd_count,
    output logic [CNT_WIDTH-1:0]           stat_drop_count
);

    logic [IW-1:0]        last_grant;
    logic [IW-1:0]        win;
    logic [N_PORTS-1:0]   grant;
    logic                 any;
    logic                 out_free;
    logic                 accept;
    logic                 runt;
    udp_hdr_t             win_hdr;
    udp_hdr_t             hdr_q;
    logic [PKT_WIDTH-1:0] win_pkt;

    dns_rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
        .req        (s_dns_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (win),
        .grant_any  (any)
    );

    assign out_free    = !m_dns_valid || m_dns_ready;
    assign accept      = enable && out_free && any;
    assign s_dns_ready = (enable && out_free) ? grant : '0;

    assign win_hdr.src_ip = s_udp_src_ip[32'(win)*32 +: 32];
    assign win_hdr.dst_ip = s_udp_dst_ip[32'(win)*32 +: 32];
    assign win_hdr.length = s_udp_length[32'(win)*16 +: 16];
    assign win_pkt        = s_dns_pkt[32'(win)*PKT_WIDTH +: PKT_WIDTH];
    assign runt           = win_hdr.length < 16'(MIN_LEN);

    assign m_udp_src_ip = hdr_q.src_ip;
    assign m_udp_dst_ip = hdr_q.dst_ip;
    assign m_udp_length = hdr_q.length;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant      <= IW'(N_PORTS - 1);
            m_dns_valid     <= 1'b0;
            hdr_q           <= '0;
            m_dns_pkt       <= '0;
            m_dns_port      <= '0;
            stat_fwd_count  <= '0;
            stat_drop_count <= '0;
        end else if (accept) begin
            last_grant <= win;
            if (!runt) begin
                hdr_q       <= win_hdr;
                m_dns_pkt   <= win_pkt;
                m_dns_port  <= win;
                m_dns_valid <= 1'b1;
                if (stat_fwd_count != '1)
                    stat_fwd_count <= stat_fwd_count + 1'b1;
            end else begin
                // runt is swallowed; the old word may still drain
                if (stat_drop_count != '1)
                    stat_drop_count <= stat_drop_count + 1'b1;
                if (m_dns_ready)
                    m_dns_valid <= 1'b0;
            end
        end else if (m_dns_ready) begin
            m_dns_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dns_pkt_arbiter.sv
// Self-checking bench: table vectors plus
// saturation and asynchronous-reset sequences.
module tb_dns_pkt_arbiter;

    localparam int N  = 4;
    localparam int PW = 64;
    localparam int ML = 20;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int CMAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [N-1:0]      s_dns_valid;
    logic [N-1:0]      s_dns_ready;
    logic [N*32-1:0]   s_udp_src_ip;
    logic [N*32-1:0]   s_udp_dst_ip;
    logic [N*16-1:0]   s_udp_length;
    logic [N*PW-1:0]   s_dns_pkt;
    logic              m_dns_valid;
    logic              m_dns_ready;
    logic [31:0]       m_udp_src_ip;
    logic [31:0]       m_udp_dst_ip;
    logic [15:0]       m_udp_length;
    logic [PW-1:0]     m_dns_pkt;
    logic [IW-1:0]     m_dns_port;
    logic [CW-1:0]     stat_fwd_count;
    logic [CW-1:0]     stat_drop_count;

    dns_pkt_arbiter #(
        .N_PORTS(N), .PKT_WIDTH(PW), .MIN_LEN(ML), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_dns_valid(s_dns_valid), .s_dns_ready(s_dns_ready),
        .s_udp_src_ip(s_udp_src_ip), .s_udp_dst_ip(s_udp_dst_ip),
        .s_udp_length(s_udp_length), .s_dns_pkt(s_dns_pkt),
        .m_dns_valid(m_dns_valid), .m_dns_ready(m_dns_ready),
        .m_udp_src_ip(m_udp_src_ip), .m_udp_dst_ip(m_udp_dst_ip),
        .m_udp_length(m_udp_length), .m_dns_pkt(m_dns_pkt),
        .m_dns_port(m_dns_port),
        .stat_fwd_count(stat_fwd_count),
        .stat_drop_count(stat_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] port;
        logic [31:0]   src;
        logic [31:0]   dst;
        logic [15:0]   len;
        logic [PW-1:0] pkt;
    } exp_t;

    typedef struct {
        logic       en;
        logic       mrdy;
        logic [3:0] v;
        logic [3:0] runt;
        logic [3:0] exp_rdy;
    } vec_t;

    exp_t q[$];
    vec_t tbl[20];

    int   errors = 0;
    int   checks = 0;
    int   m_ptr;
    logic m_mv;
    int   m_fwd;
    int   m_drop;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = N - 1;
        m_mv   = 1'b0;
        m_fwd  = 0;
        m_drop = 0;
        q.delete();
    endtask

    task automatic drive(input logic en, input logic mrdy,
                         input logic [3:0] v, input logic [3:0] runt);
        enable      = en;
        m_dns_ready = mrdy;
        s_dns_valid = v;
        for (int i = 0; i < N; i++) begin
            s_udp_src_ip[i*32 +: 32] = $urandom;
            s_udp_dst_ip[i*32 +: 32] = $urandom;
            s_dns_pkt[i*PW +: PW]    = {$urandom, $urandom};
            if (runt[i])
                s_udp_length[i*16 +: 16] = 16'(ML - 1);
            else if ($urandom_range(0, 1) == 0)
                s_udp_length[i*16 +: 16] = 16'(ML);
            else
                s_udp_length[i*16 +: 16] = 16'(ML + $urandom_range(1, 500));
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step(input logic [3:0] exp_rdy, input logic use_exp);
        logic [3:0] rdy_m;
        int   win;
        logic free;
        logic acc;
        logic drained;
        exp_t e;
        #1;
        free = !m_mv || m_dns_ready;
        win  = -1;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (win < 0 && s_dns_valid[p]) win = p;
        end
        acc   = enable && free && (win >= 0);
        rdy_m = '0;
        if (acc) rdy_m[win] = 1'b1;
        chk("s_dns_ready", 64'(s_dns_ready), 64'(rdy_m));
        if (use_exp) chk("tbl_ready", 64'(s_dns_ready), 64'(exp_rdy));
        drained = m_mv && m_dns_ready;
        if (drained) void'(q.pop_front());
        if (acc) begin
            m_ptr = win;
            if (s_udp_length[win*16 +: 16] >= 16'(ML)) begin
                e.port = IW'(win);
                e.src  = s_udp_src_ip[win*32 +: 32];
                e.dst  = s_udp_dst_ip[win*32 +: 32];
                e.len  = s_udp_length[win*16 +: 16];
                e.pkt  = s_dns_pkt[win*PW +: PW];
                q.push_back(e);
                m_mv = 1'b1;
                if (m_fwd < CMAX) m_fwd++;
            end else begin
                if (m_drop < CMAX) m_drop++;
                if (drained) m_mv = 1'b0;
            end
        end else if (drained) begin
            m_mv = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("m_dns_valid", 64'(m_dns_valid), 64'(m_mv));
        if (m_mv) begin
            chk("sb_depth", 64'(q.size()), 64'd1);
            if (q.size() > 0) begin
                chk("m_dns_port", 64'(m_dns_port), 64'(q[0].port));
                chk("m_udp_src_ip", 64'(m_udp_src_ip), 64'(q[0].src));
                chk("m_udp_dst_ip", 64'(m_udp_dst_ip), 64'(q[0].dst));
                chk("m_udp_length", 64'(m_udp_length), 64'(q[0].len));
                chk("m_dns_pkt", 64'(m_dns_pkt), 64'(q[0].pkt));
            end
        end
        chk("stat_fwd", 64'(stat_fwd_count), 64'(m_fwd));
        chk("stat_drop", 64'(stat_drop_count), 64'(m_drop));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        model_reset();

        //           en    mrdy  valid    runt     exp_ready
        tbl[0]  = '{1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100};
        tbl[1]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000};
        tbl[2]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001};
        tbl[3]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010};
        tbl[4]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100};
        tbl[5]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000};
        tbl[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0001};
        tbl[8]  = '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000};
        tbl[10] = '{1'b1, 1'b1, 4'b0011, 4'b0000, 4'b0010};
        tbl[11] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0010};
        tbl[12] = '{1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010};
        tbl[13] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        tbl[14] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        tbl[15] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100};
        tbl[16] = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001};
        tbl[17] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[18] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        tbl[19] = '{1'b1, 1'b0, 4'b1001, 4'b0000, 4'b1000};

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(m_dns_valid), 64'd0);
        chk("rst_port", 64'(m_dns_port), 64'd0);
        chk("rst_pkt", 64'(m_dns_pkt), 64'd0);
        chk("rst_len", 64'(m_udp_length), 64'd0);
        chk("rst_fwd", 64'(stat_fwd_count), 64'd0);
        chk("rst_drop", 64'(stat_drop_count), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].en, tbl[i].mrdy, tbl[i].v, tbl[i].runt);
            step(tbl[i].exp_rdy, 1'b1);
        end

        // forward counter saturation
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 4'b1111, 4'b0000);
            step(4'b0000, 1'b0);
        end
        chk("fwd_sat", 64'(stat_fwd_count), 64'(CMAX));

        // drop counter saturation, runts never reach the output
        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 4'b1111, 4'b1111);
            step(4'b0000, 1'b0);
        end
        chk("drop_sat", 64'(stat_drop_count), 64'(CMAX));
        chk("drop_no_fwd", 64'(stat_fwd_count), 64'd0);

        // asynchronous reset mid-cycle while output is valid
        do_reset();
        drive(1'b1, 1'b0, 4'b0110, 4'b0000);
        step(4'b0010, 1'b1);
        drive(1'b1, 1'b0, 4'b1111, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(m_dns_valid), 64'd0);
        chk("arst_fwd", 64'(stat_fwd_count), 64'd0);
        chk("arst_pkt", 64'(m_dns_pkt), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'b1111, 4'b0000);
        step(4'b0001, 1'b1);
        chk("arst_port0", 64'(m_dns_port), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
